// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: PC-unit request, byte-wide ROM port and decode-side instruction handshake.
// The fetch unit takes the slave modport; the PC unit, ROM and decode side together act as master.
interface instr_fetch_unit_if #(
   parameter int ROM_WIDTH     = 8,
   parameter int ROM_ADDR_BITS = 11,
   parameter int PC_WIDTH      = 12
);
   logic [PC_WIDTH-1:0]      pc;
   logic                     pc_valid;
   logic                     fetch_busy;
   logic [ROM_ADDR_BITS-1:0] rom_addr;
   logic [ROM_WIDTH-1:0]     rom_data;
   logic [31:0]              instr;
   logic [PC_WIDTH-1:0]      instr_pc;
   logic                     instr_valid;
   logic                     instr_ready;
   logic                     fetch_fault;

   modport slave (
      input  pc, pc_valid, rom_data, instr_ready,
      output fetch_busy, rom_addr, instr, instr_pc, instr_valid, fetch_fault
   );

   modport master (
      output pc, pc_valid, rom_data, instr_ready,
      input  fetch_busy, rom_addr, instr, instr_pc, instr_valid, fetch_fault
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: reads four ROM bytes little-endian into one 32-bit instruction.
// Macro FETCH_ALIGN_CHECK_EN: misaligned or out-of-range PCs yield a NOP with fetch_fault set.
module instr_fetch_unit #(
   parameter int ROM_WIDTH     = 8,
   parameter int ROM_ADDR_BITS = 11,
   parameter int PC_WIDTH      = 12
) (
   input logic               clk,
   input logic               rst,
   instr_fetch_unit_if.slave bus
);
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [ROM_ADDR_BITS-1:0] ADDR_ONE = {{(ROM_ADDR_BITS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_e;

   state_e                   state_q, state_d;
   logic [ROM_ADDR_BITS-1:0] rom_addr_q, rom_addr_d;
   logic [2:0]               cnt_q, cnt_d;
   logic [31:0]              instr_q, instr_d;
   logic [PC_WIDTH-1:0]      instr_pc_q, instr_pc_d;
   logic                     valid_q, valid_d;
   logic                     fault_q, fault_d;
   logic                     busy_q, busy_d;
   logic [ROM_ADDR_BITS-1:0] base_s;
   logic [1:0]               lane_s;
   logic                     fault_s;

   assign base_s = {bus.pc[ROM_ADDR_BITS-1:2], 2'b00};
   // cnt_q counts cycles since accept; ROM data trails its address by one cycle, so lane = cnt-1
   assign lane_s = cnt_q[1:0] - 2'd1;

`ifdef FETCH_ALIGN_CHECK_EN
   assign fault_s = (bus.pc[1:0] != 2'b00) || (|bus.pc[PC_WIDTH-1:ROM_ADDR_BITS]);
`else
   assign fault_s = 1'b0;
`endif

   // Next-state and datapath update for the IDLE/FETCH/DRAIN/HOLD sequence
   always_comb begin
      state_d    = state_q;
      rom_addr_d = rom_addr_q;
      cnt_d      = cnt_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      valid_d    = valid_q;
      fault_d    = fault_q;
      busy_d     = busy_q;
      case (state_q)
         IDLE: begin
            if (bus.pc_valid) begin
               instr_pc_d = bus.pc;
               busy_d     = 1'b1;
               cnt_d      = 3'd0;
               if (fault_s) begin
                  instr_d = NOP_INSTR;
                  fault_d = 1'b1;
                  state_d = HOLD;
               end else begin
                  rom_addr_d = base_s;
                  state_d    = FETCH;
               end
            end else begin
               state_d = IDLE;
            end
         end
         FETCH: begin
            rom_addr_d = rom_addr_q + ADDR_ONE;
            cnt_d      = cnt_q + 3'd1;
            if (cnt_q != 3'd0) begin
               instr_d[{lane_s, 3'b000} +: ROM_WIDTH] = bus.rom_data;
            end else begin
               instr_d = instr_q;
            end
            if (cnt_q == 3'd2) begin
               state_d = DRAIN;
            end else begin
               state_d = FETCH;
            end
         end
         DRAIN: begin
            cnt_d = cnt_q + 3'd1;
            instr_d[{lane_s, 3'b000} +: ROM_WIDTH] = bus.rom_data;
            if (cnt_q == 3'd4) begin
               valid_d = 1'b1;
               state_d = HOLD;
            end else begin
               state_d = DRAIN;
            end
         end
         HOLD: begin
            // The fault path enters HOLD with valid low and raises it one cycle later
            if (!valid_q) begin
               valid_d = 1'b1;
            end else if (bus.instr_ready) begin
               valid_d = 1'b0;
               fault_d = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rom_addr_q <= {ROM_ADDR_BITS{1'b0}};
         cnt_q      <= 3'd0;
         instr_q    <= NOP_INSTR;
         instr_pc_q <= {PC_WIDTH{1'b0}};
         valid_q    <= 1'b0;
         fault_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rom_addr_q <= rom_addr_d;
         cnt_q      <= cnt_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
         fault_q    <= fault_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.rom_addr    = rom_addr_q;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.instr_valid = valid_q;
   assign bus.fetch_fault = fault_q;
   assign bus.fetch_busy  = busy_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a synchronous byte ROM model.
// Covers both builds of FETCH_ALIGN_CHECK_EN.
module tb_instr_fetch_unit;
   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;
   int   xfer_cnt;
   int   x0;
   logic [7:0] rom [0:2047];

   instr_fetch_unit_if #(.ROM_WIDTH(8), .ROM_ADDR_BITS(11), .PC_WIDTH(12)) bus ();

   instr_fetch_unit #(.ROM_WIDTH(8), .ROM_ADDR_BITS(11), .PC_WIDTH(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM: data follows the address by one clock
   always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

   // Count completed decode handshakes
   always @(posedge clk) if (bus.instr_valid && bus.instr_ready) xfer_cnt++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   initial begin
      n_pass   = 0;
      n_total  = 0;
      xfer_cnt = 0;
      for (int i = 0; i < 2048; i++) rom[i] = 8'h00;
      rom[0] = 8'h93; rom[1] = 8'h00; rom[2] = 8'h10; rom[3] = 8'h00;
      rom[4] = 8'h13; rom[5] = 8'h05; rom[6] = 8'h10; rom[7] = 8'h00;
      rom[2044] = 8'h6F; rom[2045] = 8'h00; rom[2046] = 8'h00; rom[2047] = 8'h00;

      rst             = 1'b1;
      bus.pc          = 12'h000;
      bus.pc_valid    = 1'b0;
      bus.instr_ready = 1'b0;
      ticks(2);
      chk("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
      chk("rst_instr", bus.instr, 32'h0000_0013);
      chk("rst_instr_pc", 32'(bus.instr_pc), 32'h0);
      chk("rst_valid", 32'(bus.instr_valid), 32'h0);
      chk("rst_fault", 32'(bus.fetch_fault), 32'h0);
      chk("rst_busy", 32'(bus.fetch_busy), 32'h0);
      rst = 1'b0;
      tick();

      // Basic fetch of 0x004 with decode always ready
      bus.pc = 12'h004; bus.pc_valid = 1'b1; bus.instr_ready = 1'b1;
      tick();
      bus.pc_valid = 1'b0;
      chk("t1_busy_e0", 32'(bus.fetch_busy), 32'h1);
      chk("t1_addr_e0", 32'(bus.rom_addr), 32'h004);
      chk("t1_valid_e0", 32'(bus.instr_valid), 32'h0);
      tick();
      chk("t1_addr_e1", 32'(bus.rom_addr), 32'h005);
      ticks(2);
      chk("t1_addr_e3", 32'(bus.rom_addr), 32'h007);
      tick();
      chk("t1_valid_e4", 32'(bus.instr_valid), 32'h0);
      chk("t1_addr_e4", 32'(bus.rom_addr), 32'h007);
      tick();
      chk("t1_valid_e5", 32'(bus.instr_valid), 32'h1);
      chk("t1_instr", bus.instr, 32'h0010_0513);
      chk("t1_instr_pc", 32'(bus.instr_pc), 32'h004);
      chk("t1_fault", 32'(bus.fetch_fault), 32'h0);
      chk("t1_busy_e5", 32'(bus.fetch_busy), 32'h1);
      tick();
      chk("t1_valid_e6", 32'(bus.instr_valid), 32'h0);
      chk("t1_busy_e6", 32'(bus.fetch_busy), 32'h0);

      // Backpressure: ready low for four cycles, stray pc_valid during HOLD
      bus.pc = 12'h004; bus.pc_valid = 1'b1; bus.instr_ready = 1'b0;
      x0 = xfer_cnt;
      tick();
      bus.pc_valid = 1'b0;
      ticks(5);
      chk("t2_valid_e5", 32'(bus.instr_valid), 32'h1);
      bus.pc = 12'h100; bus.pc_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t2_valid_hold", 32'(bus.instr_valid), 32'h1);
         chk("t2_instr_hold", bus.instr, 32'h0010_0513);
         chk("t2_addr_hold", 32'(bus.rom_addr), 32'h007);
      end
      bus.instr_ready = 1'b1; bus.pc_valid = 1'b0; bus.pc = 12'h004;
      tick();
      chk("t2_valid_done", 32'(bus.instr_valid), 32'h0);
      chk("t2_busy_done", 32'(bus.fetch_busy), 32'h0);
      chk("t2_xfers", 32'(xfer_cnt - x0), 32'h1);
      tick();
      chk("t2_idle_busy", 32'(bus.fetch_busy), 32'h0);
      chk("t2_idle_addr", 32'(bus.rom_addr), 32'h007);

      // Back-to-back fetches 0x000 then 0x7FC with pc_valid held high
      bus.pc = 12'h000; bus.pc_valid = 1'b1; bus.instr_ready = 1'b1;
      tick();
      chk("t3_addr_a", 32'(bus.rom_addr), 32'h000);
      bus.pc = 12'h7FC;
      ticks(5);
      chk("t3_valid_a", 32'(bus.instr_valid), 32'h1);
      chk("t3_instr_a", bus.instr, 32'h0010_0093);
      tick();
      chk("t3_valid_hs", 32'(bus.instr_valid), 32'h0);
      chk("t3_busy_hs", 32'(bus.fetch_busy), 32'h0);
      chk("t3_addr_hs", 32'(bus.rom_addr), 32'h003);
      tick();
      chk("t3_busy_b", 32'(bus.fetch_busy), 32'h1);
      chk("t3_addr_b0", 32'(bus.rom_addr), 32'h7FC);
      bus.pc_valid = 1'b0;
      tick();
      chk("t3_addr_b1", 32'(bus.rom_addr), 32'h7FD);
      tick();
      chk("t3_addr_b2", 32'(bus.rom_addr), 32'h7FE);
      tick();
      chk("t3_addr_b3", 32'(bus.rom_addr), 32'h7FF);
      tick();
      chk("t3_addr_drain", 32'(bus.rom_addr), 32'h7FF);
      chk("t3_valid_drain", 32'(bus.instr_valid), 32'h0);
      tick();
      chk("t3_valid_b", 32'(bus.instr_valid), 32'h1);
      chk("t3_instr_b", bus.instr, 32'h0000_006F);
      chk("t3_instr_pc_b", 32'(bus.instr_pc), 32'h7FC);
      tick();
      chk("t3_valid_b_hs", 32'(bus.instr_valid), 32'h0);

      // Misaligned PC 0x006
      bus.pc = 12'h006; bus.pc_valid = 1'b1;
      tick();
      bus.pc_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      chk("f6_valid_e0", 32'(bus.instr_valid), 32'h0);
      chk("f6_busy_e0", 32'(bus.fetch_busy), 32'h1);
      chk("f6_addr_e0", 32'(bus.rom_addr), 32'h7FF);
      tick();
      chk("f6_valid_e1", 32'(bus.instr_valid), 32'h1);
      chk("f6_instr", bus.instr, 32'h0000_0013);
      chk("f6_fault", 32'(bus.fetch_fault), 32'h1);
      chk("f6_instr_pc", 32'(bus.instr_pc), 32'h006);
      tick();
      chk("f6_fault_hs", 32'(bus.fetch_fault), 32'h0);
      chk("f6_busy_hs", 32'(bus.fetch_busy), 32'h0);
`else
      chk("a6_addr_e0", 32'(bus.rom_addr), 32'h004);
      ticks(5);
      chk("a6_valid", 32'(bus.instr_valid), 32'h1);
      chk("a6_instr", bus.instr, 32'h0010_0513);
      chk("a6_fault", 32'(bus.fetch_fault), 32'h0);
      chk("a6_instr_pc", 32'(bus.instr_pc), 32'h006);
      tick();
      chk("a6_valid_hs", 32'(bus.instr_valid), 32'h0);
`endif

      // Out-of-range PC 0x800
      bus.pc = 12'h800; bus.pc_valid = 1'b1;
      tick();
      bus.pc_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      chk("f8_valid_e0", 32'(bus.instr_valid), 32'h0);
      tick();
      chk("f8_valid_e1", 32'(bus.instr_valid), 32'h1);
      chk("f8_instr", bus.instr, 32'h0000_0013);
      chk("f8_fault", 32'(bus.fetch_fault), 32'h1);
      chk("f8_instr_pc", 32'(bus.instr_pc), 32'h800);
      tick();
      chk("f8_fault_hs", 32'(bus.fetch_fault), 32'h0);
`else
      chk("a8_addr_e0", 32'(bus.rom_addr), 32'h000);
      ticks(5);
      chk("a8_valid", 32'(bus.instr_valid), 32'h1);
      chk("a8_instr", bus.instr, 32'h0010_0093);
      chk("a8_fault", 32'(bus.fetch_fault), 32'h0);
      chk("a8_instr_pc", 32'(bus.instr_pc), 32'h800);
      tick();
`endif

      // Reset sampled at E2 of a fetch
      bus.pc = 12'h004; bus.pc_valid = 1'b1;
      tick();
      bus.pc_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("r_valid", 32'(bus.instr_valid), 32'h0);
      chk("r_busy", 32'(bus.fetch_busy), 32'h0);
      chk("r_instr", bus.instr, 32'h0000_0013);
      chk("r_addr", 32'(bus.rom_addr), 32'h000);
      chk("r_instr_pc", 32'(bus.instr_pc), 32'h000);
      chk("r_fault", 32'(bus.fetch_fault), 32'h0);
      rst = 1'b0;
      tick();
      chk("r_busy_after", 32'(bus.fetch_busy), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
